// File: rtl/sram_rw_arbiter.sv
// Two-requester arbiter/sequencer for the read/write port of the 32x256 SRAM macro.
// One single-word access at a time; all outputs are registered.
module sram_rw_arbiter #(
  parameter int SRAM_ADDR_WD = 8,
  parameter int SRAM_DATA_WD = 32
) (
  input  logic                      wb_clk_i,
  input  logic                      rst_n,
  input  logic                      prio_fix,
  input  logic                      r0_req,
  input  logic                      r0_we,
  input  logic [SRAM_ADDR_WD-1:0]   r0_addr,
  input  logic [SRAM_DATA_WD/8-1:0] r0_wmask,
  input  logic [SRAM_DATA_WD-1:0]   r0_wdata,
  output logic                      r0_ack,
  output logic [SRAM_DATA_WD-1:0]   r0_rdata,
  input  logic                      r1_req,
  input  logic                      r1_we,
  input  logic [SRAM_ADDR_WD-1:0]   r1_addr,
  input  logic [SRAM_DATA_WD/8-1:0] r1_wmask,
  input  logic [SRAM_DATA_WD-1:0]   r1_wdata,
  output logic                      r1_ack,
  output logic [SRAM_DATA_WD-1:0]   r1_rdata,
  output logic                      sram_csb,
  output logic                      sram_web,
  output logic [SRAM_DATA_WD/8-1:0] sram_wmask,
  output logic [SRAM_ADDR_WD-1:0]   sram_addr,
  output logic [SRAM_DATA_WD-1:0]   sram_din,
  input  logic [SRAM_DATA_WD-1:0]   sram_dout,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_r, nxt_s;
  logic   sel_s;
  logic   issue_s;
  logic   win_r;
  logic   last_r;

  // Winner selection and next-state logic; sram_web doubles as the latched read/write flag
  always_comb begin
    sel_s   = 1'b0;
    nxt_s   = state_r;
    issue_s = 1'b0;
    if (r0_req && r1_req) begin
      if (prio_fix) begin
        sel_s = 1'b0;
      end else begin
        sel_s = ~last_r;
      end
    end else if (r1_req) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    case (state_r)
      IDLE: begin
        if (r0_req || r1_req) begin
          nxt_s   = CMD;
          issue_s = 1'b1;
        end else begin
          nxt_s = IDLE;
        end
      end
      CMD: begin
        if (sram_web) begin
          nxt_s = RD_WAIT;
        end else begin
          nxt_s = DONE;
        end
      end
      RD_WAIT: nxt_s = DONE;
      DONE:    nxt_s = IDLE;
      default: nxt_s = IDLE;
    endcase
  end

  // FSM state, busy flag, winner and last-grant pointer
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      win_r   <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      state_r <= nxt_s;
      busy    <= (nxt_s != IDLE);
      if (issue_s) begin
        win_r <= sel_s;
      end
      if (state_r == DONE) begin
        last_r <= win_r;
      end
    end
  end

  // Macro command registers: csb/web pulse for the CMD cycle only, addr/din/wmask hold otherwise
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
    end else if (issue_s) begin
      sram_csb  <= 1'b0;
      sram_web  <= sel_s ? ~r1_we : ~r0_we;
      sram_addr <= sel_s ? r1_addr : r0_addr;
      sram_din  <= sel_s ? r1_wdata : r0_wdata;
      if (sel_s ? r1_we : r0_we) begin
        sram_wmask <= sel_s ? r1_wmask : r0_wmask;
      end else begin
        sram_wmask <= '0;
      end
    end else begin
      sram_csb <= 1'b1;
      sram_web <= 1'b1;
    end
  end

  // Completion pulses and per-requester read data capture
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      r0_ack <= (nxt_s == DONE) && !win_r;
      r1_ack <= (nxt_s == DONE) && win_r;
      if (state_r == RD_WAIT) begin
        if (win_r) begin
          r1_rdata <= sram_dout;
        end else begin
          r0_rdata <= sram_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Scoreboard bench for sram_rw_arbiter with a behavioural SRAM model.
// Stimulus pushes expected acks; the negedge monitor pops and compares.
module tb_sram_rw_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        rst_n;
  logic        prio_fix;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [7:0]  r0_addr, r1_addr;
  logic [3:0]  r0_wmask, r1_wmask;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_ack, r1_ack;
  logic [31:0] r0_rdata, r1_rdata;
  logic        sram_csb, sram_web;
  logic [3:0]  sram_wmask;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int csb_lows = 0;
  int f0, l0, f1, l1, c0;

  typedef struct {
    logic        id;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] rd_model [2] = '{32'd0, 32'd0};
  logic        prev_csb = 1'b1;
  logic [31:0] mem [256];

  sram_rw_arbiter #(.SRAM_ADDR_WD(8), .SRAM_DATA_WD(32)) dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n), .prio_fix(prio_fix),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wmask(r0_wmask),
    .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wmask(r1_wmask),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .busy(busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // SRAM macro model: command sampled on the clock edge, dout updated after it
  always @(posedge wb_clk_i) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
        end
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic id, input logic rd, input logic [31:0] d);
    exp_t e;
    e.id = id;
    e.rd = rd;
    e.data = d;
    sb.push_back(e);
  endtask

  // Holds req for n acks (caller starts just after a rising edge)
  task automatic hold_req(input logic id, input logic we, input logic [7:0] addr,
                          input logic [3:0] mask, input logic [31:0] data, input int n,
                          output int first_c, output int last_c);
    int got;
    int t;
    got = 0;
    t = 0;
    first_c = 0;
    last_c = 0;
    if (id) begin
      r1_we = we; r1_addr = addr; r1_wmask = mask; r1_wdata = data; r1_req = 1'b1;
    end else begin
      r0_we = we; r0_addr = addr; r0_wmask = mask; r0_wdata = data; r0_req = 1'b1;
    end
    while (got < n && t < 300) begin
      @(negedge wb_clk_i);
      t++;
      if ((id && r1_ack) || (!id && r0_ack)) begin
        got++;
        if (got == 1) first_c = cyc;
        last_c = cyc;
      end
    end
    chk("ack_count", got, n);
    @(posedge wb_clk_i);
    #1;
    if (id) r1_req = 1'b0;
    else r0_req = 1'b0;
  endtask

  task automatic single(input logic id, input logic we, input logic [7:0] addr,
                        input logic [3:0] mask, input logic [31:0] data, input int lat);
    int a;
    int f;
    int l;
    a = cyc;
    hold_req(id, we, addr, mask, data, 1, f, l);
    chk(we ? "write_latency" : "read_latency", f - a, lat);
  endtask

  // Monitor: pops the scoreboard on every ack and checks csb pulse shape
  always @(negedge wb_clk_i) begin
    if (!rst_n) begin
      prev_csb = 1'b1;
    end else begin
      if (r0_ack || r1_ack) begin
        chk("ack_overlap", 32'(r0_ack & r1_ack), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'({r1_ack, r0_ack}), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("grant_id", 32'(r1_ack), 32'(mon_e.id));
          if (mon_e.rd) rd_model[mon_e.id] = mon_e.data;
          chk("rdata_winner", mon_e.id ? r1_rdata : r0_rdata, rd_model[mon_e.id]);
          chk("rdata_other", mon_e.id ? r0_rdata : r1_rdata, rd_model[!mon_e.id]);
        end
      end
      if (!sram_csb) begin
        chk("csb_single_cycle", 32'(prev_csb), 32'd1);
        csb_lows++;
      end
      prev_csb = sram_csb;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    prio_fix = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = 8'h00; r0_wmask = 4'h0; r0_wdata = 32'h0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 8'h00; r1_wmask = 4'h0; r1_wdata = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_csb", 32'(sram_csb), 32'd1);
    chk("rst_web", 32'(sram_web), 32'd1);
    chk("rst_wmask", 32'(sram_wmask), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_din", sram_din, 32'd0);
    chk("rst_acks", 32'({r1_ack, r0_ack}), 32'd0);
    chk("rst_r0_rdata", r0_rdata, 32'd0);
    chk("rst_r1_rdata", r1_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge wb_clk_i);
    #2 rst_n = 1'b1;
    @(posedge wb_clk_i);
    #1;

    // Reset during CMD (ph=1) and during RD_WAIT (ph=2) of an r0 read
    for (int ph = 1; ph <= 2; ph++) begin
      r0_we = 1'b0; r0_addr = 8'h05; r0_req = 1'b1;
      @(posedge wb_clk_i);
      if (ph == 2) @(posedge wb_clk_i);
      #2;
      if (ph == 1) chk("cmd_csb_low", 32'(sram_csb), 32'd0);
      chk("busy_mid_access", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_csb", 32'(sram_csb), 32'd1);
      chk("abort_acks", 32'({r1_ack, r0_ack}), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      r0_req = 1'b0;
      @(posedge wb_clk_i);
      #2 rst_n = 1'b1;
      repeat (6) @(posedge wb_clk_i);
      #1;
      chk("post_abort_busy", 32'(busy), 32'd0);
    end

    // r0 write/read, including a zero-mask write that must leave the word intact
    push(1'b0, 1'b0, 32'h0);
    single(1'b0, 1'b1, 8'h12, 4'hF, 32'hDEADBEEF, 2);
    push(1'b0, 1'b1, 32'hDEADBEEF);
    single(1'b0, 1'b0, 8'h12, 4'h0, 32'h0, 3);
    push(1'b0, 1'b0, 32'h0);
    single(1'b0, 1'b1, 8'h12, 4'h0, 32'h0, 2);
    push(1'b0, 1'b1, 32'hDEADBEEF);
    single(1'b0, 1'b0, 8'h12, 4'h0, 32'h0, 3);
    repeat (2) @(posedge wb_clk_i);
    #1;

    // Byte-masked write by r1
    push(1'b1, 1'b0, 32'h0);
    single(1'b1, 1'b1, 8'h40, 4'hF, 32'h11223344, 2);
    push(1'b1, 1'b0, 32'h0);
    single(1'b1, 1'b1, 8'h40, 4'b0101, 32'hAABBCCDD, 2);
    push(1'b1, 1'b1, 32'h11BB33DD);
    single(1'b1, 1'b0, 8'h40, 4'h0, 32'h0, 3);
    repeat (2) @(posedge wb_clk_i);
    #1;

    // Round-robin: last grant was r1, so r0 takes the first tie
    prio_fix = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 1'b0, 32'h0);
      push(1'b1, 1'b0, 32'h0);
    end
    fork
      hold_req(1'b0, 1'b1, 8'h80, 4'hF, 32'h0000_0080, 4, f0, l0);
      hold_req(1'b1, 1'b1, 8'h81, 4'hF, 32'h0000_0081, 4, f1, l1);
    join
    chk("rr_r0_spacing", l0 - f0, 18);
    chk("rr_r1_spacing", l1 - f1, 18);
    repeat (2) @(posedge wb_clk_i);
    #1;

    // Fixed priority: r1 waits until r0 drops its request
    prio_fix = 1'b1;
    push(1'b0, 1'b0, 32'h0);
    push(1'b0, 1'b0, 32'h0);
    push(1'b0, 1'b0, 32'h0);
    push(1'b1, 1'b0, 32'h0);
    fork
      hold_req(1'b0, 1'b1, 8'h90, 4'hF, 32'h0000_0090, 3, f0, l0);
      hold_req(1'b1, 1'b1, 8'h91, 4'hF, 32'h0000_0091, 1, f1, l1);
    join
    chk("fixed_r1_after_r0", 32'(f1 > l0), 32'd1);
    repeat (2) @(posedge wb_clk_i);
    #1;

    // Back-to-back reads by r0 with req held across acks
    prio_fix = 1'b0;
    c0 = csb_lows;
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 32'h11BB33DD);
    hold_req(1'b0, 1'b0, 8'h40, 4'h0, 32'h0, 3, f0, l0);
    chk("b2b_read_spacing", l0 - f0, 8);
    chk("b2b_csb_pulses", csb_lows - c0, 3);

    repeat (4) @(posedge wb_clk_i);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
